// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a 16-bit asynchronous SRAM: a 32-bit data port and a
// read-only fetch port, round-robin on ties, each word moved as two timed halfword accesses.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        busy,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [2:0] CNT_LAST = 3'(WAIT_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic        owner_if;
  logic        we_l;
  logic        last_if;
  logic        dq_oe;
  logic [16:0] addr_l;
  logic [31:0] wdata_l;
  logic [15:0] dq_out;
  logic [15:0] rdata_lo;

  logic        grant;
  logic        grant_if;
  logic        grant_we;
  logic [16:0] grant_addr;
  logic        cnt_end;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:19], mem_addr[1:0], if_addr[31:19], if_addr[1:0]};

  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

  // Fetch wins a tie only when the data side was the last one served.
  always_comb begin
    grant      = (state == IDLE) && (mem_req || if_req);
    grant_if   = if_req && (!mem_req || !last_if);
    grant_we   = !grant_if && mem_we;
    grant_addr = grant_if ? if_addr[18:2] : mem_addr[18:2];
    cnt_end    = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      owner_if  <= 1'b0;
      we_l      <= 1'b0;
      last_if   <= 1'b1;
      mem_ready <= 1'b0;
      if_ready  <= 1'b0;
      mem_rdata <= 32'd0;
      if_rdata  <= 32'd0;
      busy      <= 1'b0;
      SRAM_WE_N <= 1'b1;
      SRAM_ADDR <= 18'd0;
      dq_oe     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state     <= LO;
            cnt       <= 3'd0;
            owner_if  <= grant_if;
            we_l      <= grant_we;
            last_if   <= grant_if;
            busy      <= 1'b1;
            SRAM_ADDR <= {grant_addr, 1'b0};
            SRAM_WE_N <= ~grant_we;
            dq_oe     <= grant_we;
          end
        end
        LO: begin
          if (cnt_end) begin
            state     <= HI;
            cnt       <= 3'd0;
            SRAM_ADDR <= {addr_l, 1'b1};
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        HI: begin
          if (cnt_end) begin
            state     <= DONE;
            cnt       <= 3'd0;
            SRAM_ADDR <= 18'd0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            // Upper halfword is taken straight off the bus on the closing edge of HI.
            if (owner_if) begin
              if_ready <= 1'b1;
              if_rdata <= {SRAM_DQ, rdata_lo};
            end else begin
              mem_ready <= 1'b1;
              if (!we_l) mem_rdata <= {SRAM_DQ, rdata_lo};
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          if_ready  <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latched request payload and bus data; these never need a reset value.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_l  <= grant_addr;
      wdata_l <= mem_wdata;
      dq_out  <= mem_wdata[15:0];
    end
    if (state == LO && cnt_end) begin
      rdata_lo <= SRAM_DQ;
      dq_out   <= wdata_l[31:16];
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM array model, word-level reference memory, per-port
// scoreboards popped by a ready monitor, directed protocol cases and random traffic.
module tb_sram_arbiter;
  localparam int W   = 2;
  localparam int LAT = 1 + 2 * W;

  typedef struct {
    logic [31:0] rdata;
    int          issue;
    int          lat;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        busy;
  wire  [15:0] sram_dq;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;

  logic        m1_req = 1'b0;
  logic [31:0] m1_addr = 32'd0;
  logic        m1_ready, m1_if_ready, m1_busy, m1_we_n;
  logic [31:0] m1_rdata, m1_if_rdata;
  wire  [15:0] m1_dq;
  logic [17:0] m1_sram_addr;

  logic [15:0] sram [0:262143];
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_mem_rd = 32'd0;
  sb_t         mem_q[$];
  sb_t         if_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .busy(busy), .SRAM_DQ(sram_dq), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_req(m1_req), .mem_we(1'b0), .mem_addr(m1_addr), .mem_wdata(32'd0),
    .mem_ready(m1_ready), .mem_rdata(m1_rdata),
    .if_req(1'b0), .if_addr(32'd0), .if_ready(m1_if_ready), .if_rdata(m1_if_rdata),
    .busy(m1_busy), .SRAM_DQ(m1_dq), .SRAM_ADDR(m1_sram_addr), .SRAM_WE_N(m1_we_n)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq = SRAM_WE_N ? sram[SRAM_ADDR] : 16'hzzzz;
  assign m1_dq   = m1_we_n ? 16'(m1_sram_addr + 18'h1234) : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= sram_dq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input int word);
    return {13'($urandom), 9'd0, 8'(word), 2'($urandom)};
  endfunction

  task automatic check_pins(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int k);
    logic hi;
    if (k <= 2 * W) begin
      hi = (k > W);
      check("sram_addr", 32'(SRAM_ADDR), {14'd0, addr[18:2], hi});
      check("sram_we_n", 32'(SRAM_WE_N), 32'(!we));
      if (we) check("sram_dq", 32'(sram_dq), 32'(hi ? wdata[31:16] : wdata[15:0]));
      check("busy_active", 32'(busy), 32'd1);
    end else begin
      check("done_addr", 32'(SRAM_ADDR), 32'd0);
      check("done_we_n", 32'(SRAM_WE_N), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
    end
  endtask

  task automatic run_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit pins, input int exp_lat);
    sb_t e;
    int  k;
    e.issue = cyc;
    e.lat   = exp_lat;
    if (we) begin
      ref_mem[addr[9:2]] = wdata;
      e.rdata = last_mem_rd;
    end else begin
      e.rdata = ref_mem[addr[9:2]];
      last_mem_rd = e.rdata;
    end
    mem_q.push_back(e);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    k = 0;
    do begin
      tick();
      k++;
      if (pins && k <= 2 * W + 1) check_pins(we, addr, wdata, k);
      if (pins && k == 1) begin
        mem_we = ~we; mem_addr = $urandom; mem_wdata = $urandom;
      end
    end while (!mem_ready && k < 200);
    check("mem_timeout", 32'(mem_ready), 32'd1);
    mem_req = 1'b0;
  endtask

  task automatic run_if(input logic [31:0] addr, input bit pins, input int exp_lat);
    sb_t e;
    int  k;
    e.issue = cyc;
    e.lat   = exp_lat;
    e.rdata = ref_mem[addr[9:2]];
    if_q.push_back(e);
    if_req = 1'b1; if_addr = addr;
    k = 0;
    do begin
      tick();
      k++;
      if (pins && k <= 2 * W + 1) check_pins(1'b0, addr, 32'd0, k);
      if (pins && k == 1) if_addr = $urandom;
    end while (!if_ready && k < 200);
    check("if_timeout", 32'(if_ready), 32'd1);
    if_req = 1'b0;
  endtask

  // Ready monitor: every pulse must match the oldest outstanding request of that port.
  always @(negedge clk) begin
    sb_t e;
    int  lat;
    if (!rst) begin
      if (mem_ready && if_ready) check("ready_overlap", 32'd1, 32'd0);
      if (mem_ready) begin
        if (mem_q.size() == 0) check("mem_spurious_ready", 32'd1, 32'd0);
        else begin
          e = mem_q.pop_front();
          lat = cyc - e.issue;
          check("mem_rdata", mem_rdata, e.rdata);
          if (e.lat >= 0) check("mem_latency", 32'(lat), 32'(e.lat));
          else check("mem_lat_bound", 32'(lat <= 3 + 4 * W), 32'd1);
        end
      end
      if (if_ready) begin
        if (if_q.size() == 0) check("if_spurious_ready", 32'd1, 32'd0);
        else begin
          e = if_q.pop_front();
          lat = cyc - e.issue;
          check("if_rdata", if_rdata, e.rdata);
          if (e.lat >= 0) check("if_latency", 32'(lat), 32'(e.lat));
          else check("if_lat_bound", 32'(lat <= 3 + 4 * W), 32'd1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int k;
    for (int w = 0; w < 256; w++) ref_mem[w] = $urandom;
    ref_mem[128] = 32'hDEADBEEF;
    for (int w = 0; w < 256; w++) begin
      sram[2 * w]     <= ref_mem[w][15:0];
      sram[2 * w + 1] <= ref_mem[w][31:16];
    end

    #1 rst = 1'b1;
    #1;
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Tie straight after reset: data first, then alternation with both sides re-requesting.
    fork
      begin
        run_mem(1'b0, 32'h0000_0208, 32'd0, 1'b0, LAT);
        tick();
        run_mem(1'b0, 32'h0000_020C, 32'd0, 1'b0, 11);
      end
      begin
        run_if(32'h0000_0040, 1'b0, 11);
        tick();
        run_if(32'h0000_0044, 1'b0, 11);
      end
    join
    tick();

    // Single-wait-state build.
    m1_req = 1'b1; m1_addr = 32'h0000_0400; t0 = cyc; k = 0;
    do begin tick(); k++; end while (!m1_ready && k < 50);
    check("w1_latency", 32'(cyc - t0), 32'd3);
    check("w1_rdata", m1_rdata, 32'h1435_1434);
    check("w1_if_ready", 32'(m1_if_ready), 32'd0);
    m1_req = 1'b0;
    tick();

    run_mem(1'b0, 32'h0000_0200, 32'd0, 1'b1, LAT);
    tick();
    run_mem(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, LAT);
    tick();
    check("sram_half_lo", 32'(sram[8]), 32'h5678);
    check("sram_half_hi", 32'(sram[9]), 32'h1234);
    run_mem(1'b0, 32'hFFF8_0013, 32'd0, 1'b1, LAT);
    tick();

    // Fetch arriving two cycles into a data access waits for IDLE.
    fork
      run_mem(1'b0, 32'h0000_0210, 32'd0, 1'b1, LAT);
      begin
        repeat (2) tick();
        run_if(32'h0000_0048, 1'b0, 9);
      end
    join
    tick();

    // Reset in the middle of a read aborts it silently.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0204;
    repeat (3) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("mid_rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("mid_rst_mem_rdata", mem_rdata, 32'd0);
    check("mid_rst_if_rdata", if_rdata, 32'd0);
    check("mid_rst_ready", 32'(mem_ready | if_ready), 32'd0);
    mem_req = 1'b0;
    last_mem_rd = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    run_mem(1'b1, 32'h0000_0300, 32'hA5A5_0F0F, 1'b1, LAT);
    tick();
    run_mem(1'b0, 32'h0000_0300, 32'd0, 1'b1, LAT);

    for (int i = 0; i < 20; i++) begin
      repeat (1 + $urandom_range(0, 2)) tick();
      if ($urandom_range(0, 3) == 0)
        run_if(mk_addr($urandom_range(0, 255)), 1'b1, LAT);
      else
        run_mem(1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 255)), $urandom, 1'b1, LAT);
    end

    fork
      begin
        for (int i = 0; i < 15; i++) begin
          repeat (1 + $urandom_range(0, 3)) tick();
          run_mem(1'($urandom_range(0, 1)), mk_addr(128 + $urandom_range(0, 127)), $urandom,
                  1'b0, -1);
        end
      end
      begin
        for (int j = 0; j < 15; j++) begin
          repeat (1 + $urandom_range(0, 3)) tick();
          run_if(mk_addr($urandom_range(0, 127)), 1'b0, -1);
        end
      end
    join

    repeat (4) tick();
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("if_q_drained", 32'(if_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
